mem_rd_checker: RTL
===================

// Module: mem_rd_checker
// PURPOSE
//  Read-data checker stage of the memory tester. Consumes one cmp_struct_t per issued read burst
//  from the transaction generator and the Avalon-MM readdata stream from the memory controller.
//  Builds the per-word byte mask, compares enabled bytes against the expected pattern and latches
//  the first mismatch (byte address + read byte) for the CSR block (CSR_TEST_RESULT/ERR_ADDR/ERR_DATA).
// PARAMETERS
//  AMM_DATA_W   512                  readdata width, bits; DATA_B_W = AMM_DATA_W/8, ADDR_B_W = clog2(DATA_B_W)
//  AMM_BURST_W  9                    burst-count width; words_count field is AMM_BURST_W-1 bits
//  CMP_ADDR_W   rtl_settings_pkg     word-address width of cmp_struct_t.start_addr
//  ADDR_W       CMP_ADDR_W+ADDR_B_W  error byte-address width
// PORTS
//  clk_i            in   1            system clock
//  rst_n_i          in   1            asynchronous, active-low reset
//  test_start_i     in   1            pulse; clears all error state, aborts current burst
//  cmp_struct_i     in   cmp_struct_t descriptor of one read burst
//  cmp_valid_i      in   1            descriptor valid
//  cmp_ready_o      out  1            descriptor accepted when valid&ready
//  readdata_i       in   AMM_DATA_W   Avalon-MM read data
//  readdatavalid_i  in   1            read data beat valid
//  err_o            out  1            sticky: a data mismatch was detected
//  err_addr_o       out  ADDR_W       byte address of first mismatch
//  err_data_o       out  8            read byte at first mismatch
//  unexp_o          out  1            sticky: readdatavalid with no descriptor loaded
//  rd_words_o       out  32           count of checked words since test_start_i (wraps)
//  busy_o           out  1            descriptor loaded or compare pipeline non-empty
// BEHAVIOUR
//  - Reset (async) and test_start_i: all outputs 0, FSM->IDLE, pipeline valids cleared, counters 0.
//  - FSM IDLE/CHECK. cmp_ready_o = (IDLE) | (CHECK & readdatavalid_i & last beat) -> zero-bubble bursts.
//    IDLE + valid: load descriptor, word_idx=0, ->CHECK. CHECK + last beat: reload if valid else ->IDLE.
//  - words_count = burst length - 1 (0 = single word). Last beat: word_idx == words_count.
//  - Byte mask = byteenable_ptrn(first, start_off, last, end_off); first = (word_idx==0).
//    Single-word burst: both offsets applied.
//  - Expected byte: FIX_DATA -> data_ptrn for every enabled byte. RND_DATA -> 8-bit LFSR
//    x^8+x^6+x^5+x^4+1, seeded with data_ptrn on load, advanced once per beat after use;
//    same value for all bytes of a beat.
//  - Pipeline: S1 registers readdata, mask, expected, word address (start_addr+word_idx, wraps
//    mod 2^CMP_ADDR_W). S2 registers check_vector + err_byte_find. err_o rises 2 cycles after the
//    offending beat. err_addr_o = {word_addr, err_byte}; lowest failing byte wins.
//  - Only first error latched; later mismatches ignored until test_start_i. Checking continues.
//  - rd_words_o increments on every beat accepted in CHECK, masked or not.
//  - readdatavalid_i in IDLE: beat dropped, unexp_o set, no counter change.
//  - test_start_i with simultaneous readdatavalid_i/cmp_valid_i: clear wins, beat and descriptor
//    dropped (cmp_ready_o forced 0 that cycle).
//  - busy_o = (CHECK) | S1 valid | S2 valid.
// STRUCTURE
//  - rtl_settings_pkg: cmp_struct_t, data_mode_t, byteenable_ptrn, check_vector, err_byte_find;
//    add LFSR_POLY constant and lfsr_next() function.
//  - Optional sub-module mem_rd_cmp_pipe (S1/S2 compare pipeline); FSM and counters in top.
// TESTING
//  1. FIX_DATA, ptrn 0xA5, start 0x10, words_count 3, offs 0/63, all bytes 0xA5 -> err_o=0, rd_words_o=4.
//  2. Same, beat 2 byte 7 = 0x00 -> err_o=1 two cycles later, err_addr_o={0x12,6'd7}, err_data_o=0x00.
//  3. Single word, start_off 4, end_off 9, bytes 0-3 and 10-63 = 0xFF, 4-9 = ptrn -> no error.
//  4. Two descriptors back-to-back, second beat stream contiguous -> cmp_ready_o high on last beat,
//     no bubble; RND_DATA seed 0x01 -> expected 0x01,0x02,... per LFSR, no error.
//  5. readdatavalid_i in IDLE -> unexp_o=1; then test_start_i -> all sticky flags and rd_words_o = 0.
//  6. rst_n_i low mid-burst (beat 1 of 4) -> outputs 0 immediately; new burst after release checks.

Source files
------------

// File: rtl/rtl_settings_pkg.sv
// Shared types, constants and helpers for the memory tester read-data checker.
// Descriptor layout and the byte-level compare helpers used by the checker and its pipeline.
package rtl_settings_pkg;

  localparam int unsigned CMP_DATA_W  = 512;
  localparam int unsigned CMP_BURST_W = 9;
  localparam int unsigned DATA_B_W    = CMP_DATA_W / 8;
  localparam int unsigned ADDR_B_W    = $clog2(DATA_B_W);
  localparam int unsigned CMP_ADDR_W  = 26;
  // Low terms of x^8+x^6+x^5+x^4+1 (x^8 is implied by the shift-out bit)
  localparam logic [7:0]  LFSR_POLY   = 8'h71;

  typedef enum logic {
    FIX_DATA = 1'b0,
    RND_DATA = 1'b1
  } data_mode_t;

  typedef struct packed {
    data_mode_t                 data_mode;
    logic [7:0]                 data_ptrn;
    logic [CMP_ADDR_W-1:0]      start_addr;
    logic [CMP_BURST_W-2:0]     words_count;
    logic [ADDR_B_W-1:0]        start_offset;
    logic [ADDR_B_W-1:0]        end_offset;
  } cmp_struct_t;

  function automatic logic [DATA_B_W-1:0] byteenable_ptrn(
    input logic                first,
    input logic [ADDR_B_W-1:0] start_off,
    input logic                last,
    input logic [ADDR_B_W-1:0] end_off
  );
    logic [DATA_B_W-1:0] be;
    be = '0;
    for (int unsigned i = 0; i < DATA_B_W; i++) begin
      be[i] = (!first || (i >= 32'(start_off))) && (!last || (i <= 32'(end_off)));
    end
    return be;
  endfunction

  function automatic logic [DATA_B_W-1:0] check_vector(
    input logic [CMP_DATA_W-1:0] data,
    input logic [DATA_B_W-1:0]   mask,
    input logic [7:0]            expected
  );
    logic [DATA_B_W-1:0] cv;
    cv = '0;
    for (int unsigned i = 0; i < DATA_B_W; i++) begin
      cv[i] = mask[i] && (data[8*i +: 8] != expected);
    end
    return cv;
  endfunction

  function automatic logic [ADDR_B_W-1:0] err_byte_find(input logic [DATA_B_W-1:0] cv);
    logic [ADDR_B_W-1:0] idx;
    logic                found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < DATA_B_W; i++) begin
      if (cv[i] && !found) begin
        idx   = ADDR_B_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? LFSR_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mem_rd_cmp_pipe.sv
// Two-stage compare pipeline: S1 captures the beat and its context, S2 evaluates the
// enabled bytes and latches only the first mismatch until cleared.
module mem_rd_cmp_pipe
  import rtl_settings_pkg::*;
#(
  parameter int unsigned DATA_W = CMP_DATA_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           in_valid,
  input  logic [DATA_W-1:0]              in_data,
  input  logic [DATA_B_W-1:0]            in_mask,
  input  logic [7:0]                     in_exp,
  input  logic [CMP_ADDR_W-1:0]          in_addr,
  output logic                           busy,
  output logic                           err,
  output logic [CMP_ADDR_W+ADDR_B_W-1:0] err_addr,
  output logic [7:0]                     err_data
);

  logic                  s1_valid;
  logic [DATA_W-1:0]     s1_data;
  logic [DATA_B_W-1:0]   s1_mask;
  logic [7:0]            s1_exp;
  logic [CMP_ADDR_W-1:0] s1_addr;
  logic                  s2_valid;

  logic [DATA_B_W-1:0]   cv;
  logic [ADDR_B_W-1:0]   byte_idx;
  logic [7:0]            hit_byte;

  always_comb begin
    cv       = check_vector(s1_data, s1_mask, s1_exp);
    byte_idx = err_byte_find(cv);
    hit_byte = s1_data[8*byte_idx +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mask  <= '0;
      s1_exp   <= '0;
      s1_addr  <= '0;
      s2_valid <= 1'b0;
      err      <= 1'b0;
      err_addr <= '0;
      err_data <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mask  <= '0;
      s1_exp   <= '0;
      s1_addr  <= '0;
      s2_valid <= 1'b0;
      err      <= 1'b0;
      err_addr <= '0;
      err_data <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mask <= in_mask;
        s1_exp  <= in_exp;
        s1_addr <= in_addr;
      end
      s2_valid <= s1_valid;
      // The error registers are the S2 stage: err rises two edges after the beat
      if (s1_valid && (|cv) && !err) begin
        err      <= 1'b1;
        err_addr <= {s1_addr, byte_idx};
        err_data <= hit_byte;
      end
    end
  end

  assign busy = s1_valid | s2_valid;

endmodule

// File: rtl/mem_rd_checker.sv
// Read-data checker: walks each burst descriptor against the readdata stream, generates the
// per-beat byte mask / expected byte, and hands beats to the compare pipeline.
module mem_rd_checker
  import rtl_settings_pkg::*;
#(
  parameter int unsigned AMM_DATA_W  = CMP_DATA_W,
  parameter int unsigned AMM_BURST_W = CMP_BURST_W
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           test_start_i,
  input  cmp_struct_t                    cmp_struct_i,
  input  logic                           cmp_valid_i,
  output logic                           cmp_ready_o,
  input  logic [AMM_DATA_W-1:0]          readdata_i,
  input  logic                           readdatavalid_i,
  output logic                           err_o,
  output logic [CMP_ADDR_W+ADDR_B_W-1:0] err_addr_o,
  output logic [7:0]                     err_data_o,
  output logic                           unexp_o,
  output logic [31:0]                    rd_words_o,
  output logic                           busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  state_t                 state;
  cmp_struct_t            cur;
  logic [AMM_BURST_W-2:0] word_idx;
  logic [7:0]             lfsr;

  logic                   last;
  logic                   beat;
  logic [DATA_B_W-1:0]    mask;
  logic [7:0]             expected;
  logic [CMP_ADDR_W-1:0]  word_addr;
  logic                   pipe_busy;

  always_comb begin
    last      = (word_idx == cur.words_count);
    beat      = (state == CHECK) && readdatavalid_i && !test_start_i;
    mask      = byteenable_ptrn(word_idx == '0, cur.start_offset, last, cur.end_offset);
    expected  = (cur.data_mode == RND_DATA) ? lfsr : cur.data_ptrn;
    word_addr = cur.start_addr + CMP_ADDR_W'(word_idx);
  end

  // Ready on the last beat lets the next descriptor load with no idle cycle between bursts
  assign cmp_ready_o = !test_start_i &&
                       ((state == IDLE) || ((state == CHECK) && readdatavalid_i && last));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      cur        <= '0;
      word_idx   <= '0;
      lfsr       <= '0;
      unexp_o    <= 1'b0;
      rd_words_o <= '0;
    end else if (test_start_i) begin
      state      <= IDLE;
      cur        <= '0;
      word_idx   <= '0;
      lfsr       <= '0;
      unexp_o    <= 1'b0;
      rd_words_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (readdatavalid_i) unexp_o <= 1'b1;
          if (cmp_valid_i) begin
            cur      <= cmp_struct_i;
            word_idx <= '0;
            lfsr     <= cmp_struct_i.data_ptrn;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (readdatavalid_i) begin
            rd_words_o <= rd_words_o + 32'd1;
            if (last) begin
              if (cmp_valid_i) begin
                cur      <= cmp_struct_i;
                word_idx <= '0;
                lfsr     <= cmp_struct_i.data_ptrn;
              end else begin
                state <= IDLE;
              end
            end else begin
              word_idx <= word_idx + 1'b1;
              lfsr     <= lfsr_next(lfsr);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_rd_cmp_pipe #(
    .DATA_W (AMM_DATA_W)
  ) u_pipe (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .clr      (test_start_i),
    .in_valid (beat),
    .in_data  (readdata_i),
    .in_mask  (mask),
    .in_exp   (expected),
    .in_addr  (word_addr),
    .busy     (pipe_busy),
    .err      (err_o),
    .err_addr (err_addr_o),
    .err_data (err_data_o)
  );

  assign busy_o = (state == CHECK) | pipe_busy;

endmodule
